ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline. It consumes the forwardA/forwardB selects from the forwarding unit and builds the forwarded ALU operands. It contains the ALU and an iterative multiply/divide unit with HI/LO registers. It produces the EX result and store data for the EX/MEM register, plus a stall request back to the hazard logic while a multiply/divide is in flight.

---
 rtl/ex_pkg.sv | 34 +++
 rtl/ex_stage_md_unit.sv | 129 ++++++++++++
 rtl/ex_stage.sv | 94 +++++++++
 tb/tb_ex_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU controls, multiply/divide ops,
// forwarding selects and the multiply/divide sequencer states.
package ex_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLL  = 4'd11;
  localparam logic [3:0] ALU_SRL  = 4'd12;
  localparam logic [3:0] ALU_SRA  = 4'd13;
  localparam logic [3:0] ALU_LUI  = 4'd14;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

endpackage

// File: rtl/ex_stage_md_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step
// per cycle on magnitudes, signs applied in a final FIX cycle, owns HI/LO.
module md_unit
  import ex_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              md_accept,
  input  logic [3:0]        md_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              md_busy
);

  localparam int CNT_W = $clog2(MD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_CYCLES - 1);

  md_state_t           state;
  logic [DATA_W-1:0]   work_hi, work_lo, opnd;
  logic [CNT_W-1:0]    cnt;
  logic                neg_q, neg_r, dz, is_div;

  logic                sgn_a, sgn_b;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod, prod_neg;

  always_comb begin
    sgn_a     = ((md_op == MD_MULT) || (md_op == MD_DIV)) && op_a[DATA_W-1];
    sgn_b     = ((md_op == MD_MULT) || (md_op == MD_DIV)) && op_b[DATA_W-1];
    abs_a     = sgn_a ? -op_a : op_a;
    abs_b     = sgn_b ? -op_b : op_b;
    mul_sum   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd : '0)};
    div_shift = {work_hi, work_lo[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    prod      = {work_hi, work_lo};
    prod_neg  = -prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      work_hi <= '0;
      work_lo <= '0;
      opnd    <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      is_div  <= 1'b0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (md_accept) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              state   <= MUL;
              work_hi <= '0;
              work_lo <= abs_b;
              opnd    <= abs_a;
              neg_q   <= sgn_a ^ sgn_b;
              is_div  <= 1'b0;
              cnt     <= '0;
              md_busy <= 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state   <= DIV;
              work_hi <= '0;
              work_lo <= abs_a;
              opnd    <= abs_b;
              neg_q   <= sgn_a ^ sgn_b;
              neg_r   <= sgn_a;
              dz      <= (op_b == '0);
              is_div  <= 1'b1;
              cnt     <= '0;
              md_busy <= 1'b1;
            end
            MD_MTHI: hi <= op_a;
            MD_MTLO: lo <= op_a;
            default: ;
          endcase
        end
        MUL: begin
          {work_hi, work_lo} <= {mul_sum, work_lo[DATA_W-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          // A zero divisor keeps the dividend magnitude in work_lo for FIX.
          if (!dz) begin
            if (!div_diff[DATA_W]) begin
              work_hi <= div_diff[DATA_W-1:0];
              work_lo <= {work_lo[DATA_W-2:0], 1'b1};
            end else begin
              work_hi <= div_shift[DATA_W-1:0];
              work_lo <= {work_lo[DATA_W-2:0], 1'b0};
            end
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state   <= IDLE;
          md_busy <= 1'b0;
          if (is_div) begin
            if (dz) begin
              lo <= '1;
              hi <= neg_r ? -work_lo : work_lo;
            end else begin
              lo <= neg_q ? -work_lo : work_lo;
              hi <= neg_r ? -work_hi : work_hi;
            end
          end else begin
            {hi, lo} <= neg_q ? prod_neg : prod;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, multiply/divide issue and the
// stall request raised while a multiply/divide occupies the unit.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        forwardA,
  input  logic [1:0]        forwardB,
  input  logic [DATA_W-1:0] id_ex_rs_data,
  input  logic [DATA_W-1:0] id_ex_rt_data,
  input  logic [DATA_W-1:0] id_ex_imm,
  input  logic [DATA_W-1:0] ex_mem_alu_result,
  input  logic [DATA_W-1:0] mem_wb_write_data,
  input  logic              id_ex_valid,
  input  logic              flush,
  input  logic              alu_src,
  input  logic [3:0]        alu_ctrl,
  input  logic [4:0]        shamt,
  input  logic [3:0]        md_op,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_data,
  output logic              zero,
  output logic              md_busy,
  output logic              ex_stall
);

  logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_out, hi, lo;
  logic              md_sel, md_accept;

  always_comb begin
    case (forwardA)
      FWD_EXMEM: op_a = ex_mem_alu_result;
      FWD_MEMWB: op_a = mem_wb_write_data;
      default:   op_a = id_ex_rs_data;
    endcase
    case (forwardB)
      FWD_EXMEM: fwd_b = ex_mem_alu_result;
      FWD_MEMWB: fwd_b = mem_wb_write_data;
      default:   fwd_b = id_ex_rt_data;
    endcase
    op_b = alu_src ? id_ex_imm : fwd_b;
  end

  always_comb begin
    case (alu_ctrl)
      ALU_AND:  alu_out = op_a & op_b;
      ALU_OR:   alu_out = op_a | op_b;
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_SLT:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_out = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_NOR:  alu_out = ~(op_a | op_b);
      ALU_SLL:  alu_out = op_b << shamt;
      ALU_SRL:  alu_out = op_b >> shamt;
      ALU_SRA:  alu_out = DATA_W'($signed(op_b) >>> shamt);
      ALU_LUI:  alu_out = {op_b[DATA_W-17:0], 16'h0};
      default:  alu_out = '0;
    endcase
  end

  assign md_sel     = id_ex_valid && !flush && (md_op != MD_NONE);
  assign md_accept  = md_sel && !md_busy;
  assign ex_stall   = md_sel && md_busy;
  assign store_data = fwd_b;

  always_comb begin
    if (md_accept && md_op == MD_MFHI)      alu_result = hi;
    else if (md_accept && md_op == MD_MFLO) alu_result = lo;
    else                                    alu_result = alu_out;
  end

  assign zero = (alu_result == '0);

  md_unit #(
    .DATA_W    (DATA_W),
    .MD_CYCLES (MD_CYCLES)
  ) u_md (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_accept (md_accept),
    .md_op     (md_op),
    .op_a      (op_a),
    .op_b      (fwd_b),
    .hi        (hi),
    .lo        (lo),
    .md_busy   (md_busy)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against an arithmetic reference.
module tb_ex_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   forwardA, forwardB;
  logic [W-1:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [W-1:0] ex_mem_alu_result, mem_wb_write_data;
  logic         id_ex_valid, flush, alu_src;
  logic [3:0]   alu_ctrl, md_op;
  logic [4:0]   shamt;
  logic [W-1:0] alu_result, store_data;
  logic         zero, md_busy, ex_stall;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(W), .MD_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .forwardA(forwardA), .forwardB(forwardB),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .ex_mem_alu_result(ex_mem_alu_result), .mem_wb_write_data(mem_wb_write_data),
    .id_ex_valid(id_ex_valid), .flush(flush), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .shamt(shamt), .md_op(md_op), .alu_result(alu_result), .store_data(store_data),
    .zero(zero), .md_busy(md_busy), .ex_stall(ex_stall)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_ex_valid = 1'b0; flush = 1'b0; md_op = 4'd0; alu_ctrl = 4'd0; alu_src = 1'b0;
    forwardA = 2'b00; forwardB = 2'b00; shamt = 5'd0;
    id_ex_rs_data = '0; id_ex_rt_data = '0; id_ex_imm = '0;
    ex_mem_alu_result = '0; mem_wb_write_data = '0;
  endtask

  task automatic set_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    id_ex_valid = 1'b1; flush = 1'b0; md_op = op;
    forwardA = 2'b00; forwardB = 2'b00;
    id_ex_rs_data = a; id_ex_rt_data = b;
  endtask

  function automatic logic [W-1:0] ref_alu(input int ctrl, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] sh);
    logic [63:0] ext;
    ext = {{32{b[31]}}, b} >> sh;
    case (ctrl)
      0:  return a & b;
      1:  return a | b;
      2:  return a + b;
      6:  return a - b;
      7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      8:  return (a < b) ? 32'd1 : 32'd0;
      9:  return a ^ b;
      10: return ~(a | b);
      11: return b << sh;
      12: return b >> sh;
      13: return ext[31:0];
      14: return {b[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a; sb = b;
    case (op)
      4'd1: begin sp = longint'(sa) * longint'(sb); {m_hi, m_lo} = sp; end
      4'd2: begin up = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = up; end
      4'd3: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 0; end
        else begin m_lo = sa / sb; m_hi = sa % sb; end
      end
      4'd4: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: ;
    endcase
  endtask

  // Issue an md op, then present MFLO immediately and count stall cycles.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int n;
    ref_md(op, a, b);
    set_md(op, a, b);
    #1 chk({tag, " issue_stall"}, {31'b0, ex_stall}, 32'd0);
    step();
    set_md(4'd6, '0, '0);
    n = 0;
    #1;
    while (ex_stall === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, " stall_cycles"}, n, 32'd33);
    chk({tag, " lo"}, alu_result, m_lo);
    step();
    md_op = 4'd5;
    #1 chk({tag, " hi"}, alu_result, m_hi);
    step();
    clear();
  endtask

  initial begin
    logic [W-1:0] a, b, exp;
    logic [4:0]   sh;
    int           ctrl, n;
    logic [3:0]   op;

    clear();
    rst_n = 1'b0;
    set_md(4'd1, 32'd3, 32'd4);
    #2;
    chk("reset md_busy", {31'b0, md_busy}, 32'd0);
    chk("reset ex_stall", {31'b0, ex_stall}, 32'd0);
    clear();
    step();
    rst_n = 1'b1;
    step();

    // Forwarding precedence
    id_ex_valid = 1'b1; alu_ctrl = 4'd2; alu_src = 1'b1; id_ex_imm = 32'd3;
    id_ex_rs_data = 32'd1; ex_mem_alu_result = 32'd5; mem_wb_write_data = 32'd9;
    forwardA = 2'b10; #1 chk("fwdA exmem", alu_result, 32'd8);
    forwardA = 2'b01; #1 chk("fwdA memwb", alu_result, 32'd12);
    forwardA = 2'b11; #1 chk("fwdA 11", alu_result, 32'd4);
    id_ex_rt_data = 32'd77;
    forwardB = 2'b10; #1 chk("store exmem", store_data, 32'd5);
    forwardB = 2'b00; #1 chk("store rt", store_data, 32'd77);
    forwardA = 2'b00; forwardB = 2'b01; alu_src = 1'b0;
    #1 chk("opB fwd memwb", alu_result, 32'd10);
    clear();

    // Randomized ALU
    for (int i = 0; i < 40; i++) begin
      ctrl = $urandom_range(0, 15);
      a = $urandom; b = (i % 4 == 0) ? a : $urandom; sh = 5'($urandom_range(0, 31));
      id_ex_valid = 1'b1; alu_ctrl = 4'(ctrl); id_ex_rs_data = a; id_ex_rt_data = b; shamt = sh;
      exp = ref_alu(ctrl, a, b, sh);
      #1 chk($sformatf("alu ctrl%0d", ctrl), alu_result, exp);
      chk("alu zero", {31'b0, zero}, (exp == 0) ? 32'd1 : 32'd0);
    end
    clear();
    step();

    run_md("mult signed", 4'd1, -32'sd3, 32'd7);
    run_md("div neg", 4'd3, -32'sd7, 32'd2);
    run_md("divu by zero", 4'd4, 32'd10, 32'd0);
    run_md("div overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div signed by zero", 4'd3, -32'sd20, 32'd0);

    // Flush on the issue cycle: nothing starts, HI/LO unchanged
    set_md(4'd1, 32'd5, 32'd6);
    flush = 1'b1;
    step();
    chk("flush issue busy", {31'b0, md_busy}, 32'd0);
    set_md(4'd6, '0, '0); #1 chk("flush lo kept", alu_result, m_lo);
    md_op = 4'd5;         #1 chk("flush hi kept", alu_result, m_hi);
    step();

    // Flush while busy: the in-flight MULT still completes
    ref_md(4'd1, 32'd1234, 32'd5678);
    set_md(4'd1, 32'd1234, 32'd5678);
    step();
    clear();
    id_ex_valid = 1'b1; alu_ctrl = 4'd2; id_ex_rs_data = 32'd2; id_ex_rt_data = 32'd3;
    #1 chk("non-md no stall", {31'b0, ex_stall}, 32'd0);
    chk("non-md result", alu_result, 32'd5);
    set_md(4'd6, '0, '0);
    flush = 1'b1;
    #1 chk("flushed no stall", {31'b0, ex_stall}, 32'd0);
    chk("flushed busy", {31'b0, md_busy}, 32'd1);
    n = 0;
    while (md_busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("flush wait bound", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    flush = 1'b0;
    #1 chk("flush mult lo", alu_result, m_lo);
    md_op = 4'd5; #1 chk("flush mult hi", alu_result, m_hi);
    step();

    // MTHI / MTLO then read back
    set_md(4'd7, 32'h0000_ABCD, '0);
    step();
    m_hi = 32'h0000_ABCD;
    md_op = 4'd5;
    #1 chk("mthi mfhi", alu_result, 32'h0000_ABCD);
    chk("mfhi no stall", {31'b0, ex_stall}, 32'd0);
    set_md(4'd8, 32'h1357_2468, '0);
    step();
    m_lo = 32'h1357_2468;
    md_op = 4'd6;
    #1 chk("mtlo mflo", alu_result, 32'h1357_2468);
    step();
    clear();

    // Reset in the middle of a DIVU
    set_md(4'd4, 32'd100, 32'd7);
    step();
    clear();
    repeat (10) step();
    rst_n = 1'b0;
    m_hi = '0; m_lo = '0;
    #1 chk("midreset busy", {31'b0, md_busy}, 32'd0);
    set_md(4'd5, '0, '0); #1 chk("midreset hi", alu_result, 32'd0);
    md_op = 4'd6;         #1 chk("midreset lo", alu_result, 32'd0);
    clear();
    step();
    rst_n = 1'b1;
    step();
    run_md("multu after reset", 4'd2, 32'hFFFF_FFFF, 32'd2);

    // Randomized multiply/divide
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom;
      if (i % 2 == 1) b = b >> $urandom_range(0, 28);
      run_md($sformatf("rand md op%0d", op), op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
